fsm_state_monitor: RTL and testbench
====================================

// Module: fsm_state_monitor
// PURPOSE
//   Downstream consumer of the 4-state sequencer's 2-bit state bus (IDLE=00, LOAD=01, PROCESS=10, DONE=11).
//   Decodes the bus into registered per-state enables and a DONE entry pulse, counts completed rounds,
//   and flags illegal transitions and wrong dwell lengths. Shares clk/reset with the sequencer.
// PARAMETERS
//   CNT_W  8  width of round_count
//   DWELL  2  required cycles per state; legal range 1..(2**RUN_W)-2
//   RUN_W  4  width of internal run-length counter
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-low reset
//   state_in     in   2      sequencer state bus, sampled every clk edge
//   clear        in   1      synchronous clear of round_count, err_seq, err_dwell
//   load_en      out  1      registered: sampled state == LOAD
//   process_en   out  1      registered: sampled state == PROCESS
//   done_pulse   out  1      1-cycle pulse on the first sampled cycle of DONE
//   round_count  out  CNT_W  completed DONE->IDLE rounds, saturating
//   err_seq      out  1      sticky: illegal transition seen
//   err_dwell    out  1      sticky: a state was held for a count other than DWELL cycles
// BEHAVIOUR
//   - Reset (reset=0, async): prev_state=IDLE, run_len=0; all outputs 0.
//   - Per edge, let s=state_in. Hold: s==prev_state -> run_len<=min(run_len+1, 2**RUN_W-1).
//   - Transition: s!=prev_state -> prev_state<=s, run_len<=1.
//     - Legal only if s==prev_state+1 mod 4; otherwise err_seq<=1.
//     - Dwell check: run_len!=DWELL -> err_dwell<=1. A saturated run_len always mismatches.
//   - The first IDLE run after reset is checked like any other run. Counting from run_len=0 matches
//     the sequencer's 2-cycle IDLE after reset.
//   - Enables decode the registered prev_state, so they lag state_in by 1 cycle.
//     done_pulse<=1 on an edge that samples a transition into DONE, else 0.
//   - round_count: +1 on a legal DONE->IDLE transition. Holds at 2**CNT_W-1 (no wrap).
//   - clear=1: round_count<=0, err_seq<=0, err_dwell<=0; prev_state and run_len are unaffected.
//     clear + increment in the same cycle: clear wins (result 0).
//     clear + newly detected error in the same cycle: error wins (flag = 1).
//   - Illegal transitions still update prev_state, so checking resumes from the new state.
//   - Reset mid-operation returns to the reset state immediately.
//     The sequencer shares reset, so there is no false err_seq.
// CONFIGURATION
//   FSM_STATE_MON_DWELL_CHECK_EN
//     defined:   run_len counter and dwell check present; err_dwell behaves as above.
//     undefined: run_len and dwell logic removed; err_dwell tied 0; DWELL and RUN_W unused.
//                Sequence checking, enables, done_pulse and round_count are unchanged.
// STRUCTURE
//   - Shared package fsm_pkg: state encodings IDLE/LOAD/PROCESS/DONE (2-bit) and a
//     next_state_of(s) constant function. The sequencer uses the same package.
//   - One sub-module, state_dwell_checker (run_len counter plus compare), instantiated only
//     under FSM_STATE_MON_DWELL_CHECK_EN.
//   - Everything else stays in the top: prev_state register, transition/legality logic,
//     decode, round counter.
// TESTING
//   - Reset, then a nominal sequence of 2 cycles per state for 3 rounds -> round_count=3, err_seq=0,
//     err_dwell=0, one done_pulse per round, load_en high for exactly 2 cycles per round.
//   - state_in IDLE->PROCESS skip -> err_seq=1 next edge and stays 1. A later legal sequence
//     still counts rounds.
//   - LOAD held 3 cycles (DWELL=2) -> err_dwell=1 at the LOAD->PROCESS edge; err_seq stays 0.
//     With the macro undefined, err_dwell stays 0.
//   - CNT_W=2, run 5 rounds -> round_count saturates at 3.
//     Pulse clear on the DONE->IDLE edge -> round_count=0.
//   - Force err_seq, then assert clear in the same cycle as a new illegal transition -> err_seq=1.
//     clear in an error-free cycle -> err_seq=0.
//   - Assert reset mid-PROCESS -> all outputs 0 asynchronously. After release, a nominal sequence
//     raises no errors.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared state encoding of the 4-state sequencer and its monitor.
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOAD    = 2'b01,
        PROCESS = 2'b10,
        DONE    = 2'b11
    } fsm_state_t;

    function automatic fsm_state_t next_state_of(input fsm_state_t s);
        return fsm_state_t'(s + 2'd1);
    endfunction

endpackage

// File: rtl/state_dwell_checker.sv
// Run-length counter for the current state; flags a run that ends after other than DWELL cycles.
module state_dwell_checker #(
    parameter int DWELL = 2,
    parameter int RUN_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic trans,
    output logic dwell_bad
);

    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam logic [RUN_W-1:0] DWELL_L = RUN_W'(DWELL);

    logic [RUN_W-1:0] run_len;

    // Saturates so a very long run still reports as a mismatch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_len <= '0;
        end else if (trans) begin
            run_len <= RUN_W'(1);
        end else if (run_len != RUN_MAX) begin
            run_len <= run_len + 1'b1;
        end
    end

    assign dwell_bad = trans && (run_len != DWELL_L);

endmodule

// File: rtl/fsm_state_monitor.sv
// Monitor for the sequencer state bus: enables, DONE pulse, round counter, sequence/dwell errors.
// Dwell checking is built only when FSM_STATE_MON_DWELL_CHECK_EN is defined.
module fsm_state_monitor
    import fsm_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int DWELL = 2,
    parameter int RUN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       state_in,
    input  logic             clear,
    output logic             load_en,
    output logic             process_en,
    output logic             done_pulse,
    output logic [CNT_W-1:0] round_count,
    output logic             err_seq,
    output logic             err_dwell
);

    if (DWELL < 1 || DWELL > (2**RUN_W) - 2) begin : g_dwell_range
        $error("fsm_state_monitor: DWELL outside 1..2**RUN_W-2");
    end

    fsm_state_t cur_state;
    fsm_state_t prev_state;
    logic       trans;
    logic       seq_bad;
    logic       round_inc;

    assign cur_state = fsm_state_t'(state_in);
    assign trans     = (cur_state != prev_state);
    assign seq_bad   = trans && (cur_state != next_state_of(prev_state));
    // A legal transition out of DONE can only land in IDLE.
    assign round_inc = trans && !seq_bad && (prev_state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_state <= IDLE;
            load_en    <= 1'b0;
            process_en <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            prev_state <= cur_state;
            load_en    <= (cur_state == LOAD);
            process_en <= (cur_state == PROCESS);
            done_pulse <= trans && (cur_state == DONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            round_count <= '0;
        end else if (clear) begin
            round_count <= '0;
        end else if (round_inc && (round_count != '1)) begin
            round_count <= round_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_seq <= 1'b0;
        end else if (seq_bad) begin
            err_seq <= 1'b1;
        end else if (clear) begin
            err_seq <= 1'b0;
        end
    end

`ifdef FSM_STATE_MON_DWELL_CHECK_EN
    logic dwell_bad;

    state_dwell_checker #(
        .DWELL (DWELL),
        .RUN_W (RUN_W)
    ) u_dwell (
        .clk       (clk),
        .reset     (reset),
        .trans     (trans),
        .dwell_bad (dwell_bad)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_dwell <= 1'b0;
        end else if (dwell_bad) begin
            err_dwell <= 1'b1;
        end else if (clear) begin
            err_dwell <= 1'b0;
        end
    end
`else
    assign err_dwell = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Self-checking bench for fsm_state_monitor: directed scenarios plus random state streams vs. a behavioural model.
module tb_fsm_state_monitor;

`ifdef FSM_STATE_MON_DWELL_CHECK_EN
    localparam bit DWELL_ON = 1'b1;
`else
    localparam bit DWELL_ON = 1'b0;
`endif
    localparam int DWELL   = 2;
    localparam int RUN_MAX = 15;
    localparam int CAP_B   = 255;
    localparam int CAP_S   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state_in;
    logic       clear;

    logic       load_en_b, process_en_b, done_pulse_b, err_seq_b, err_dwell_b;
    logic [7:0] round_count_b;
    logic       load_en_s, process_en_s, done_pulse_s, err_seq_s, err_dwell_s;
    logic [1:0] round_count_s;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_load = 0;

    // Behavioural model state
    int m_prev, m_run, m_round_b, m_round_s;
    bit m_seq, m_dwell, m_load, m_proc, m_done;

    always #5 clk = ~clk;

    fsm_state_monitor #(.CNT_W(8), .DWELL(DWELL), .RUN_W(4)) u_dut (
        .clk(clk), .reset(reset), .state_in(state_in), .clear(clear),
        .load_en(load_en_b), .process_en(process_en_b), .done_pulse(done_pulse_b),
        .round_count(round_count_b), .err_seq(err_seq_b), .err_dwell(err_dwell_b)
    );

    fsm_state_monitor #(.CNT_W(2), .DWELL(DWELL), .RUN_W(4)) u_dut_s (
        .clk(clk), .reset(reset), .state_in(state_in), .clear(clear),
        .load_en(load_en_s), .process_en(process_en_s), .done_pulse(done_pulse_s),
        .round_count(round_count_s), .err_seq(err_seq_s), .err_dwell(err_dwell_s)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_run = 0; m_round_b = 0; m_round_s = 0;
        m_seq = 0; m_dwell = 0; m_load = 0; m_proc = 0; m_done = 0;
    endtask

    task automatic model_step(input int s, input bit c);
        bit trans, bad_seq, bad_dwell, inc;
        trans     = (s != m_prev);
        bad_seq   = trans && (s != (m_prev + 1) % 4);
        bad_dwell = DWELL_ON && trans && (m_run != DWELL);
        inc       = trans && !bad_seq && (m_prev == 3);
        if (c) begin
            m_round_b = 0;
            m_round_s = 0;
        end else if (inc) begin
            if (m_round_b < CAP_B) m_round_b++;
            if (m_round_s < CAP_S) m_round_s++;
        end
        if (bad_seq) m_seq = 1; else if (c) m_seq = 0;
        if (bad_dwell) m_dwell = 1; else if (c) m_dwell = 0;
        m_load = (s == 1);
        m_proc = (s == 2);
        m_done = trans && (s == 3);
        m_run  = trans ? 1 : ((m_run < RUN_MAX) ? m_run + 1 : RUN_MAX);
        m_prev = s;
    endtask

    // One compare process against the model, every cycle.
    always @(negedge clk) begin
        chk("load_en", load_en_b, m_load);
        chk("process_en", process_en_b, m_proc);
        chk("done_pulse", done_pulse_b, m_done);
        chk("round_count", round_count_b, m_round_b);
        chk("err_seq", err_seq_b, m_seq);
        chk("err_dwell", err_dwell_b, m_dwell);
        chk("s_load_en", load_en_s, m_load);
        chk("s_round_count", round_count_s, m_round_s);
        chk("s_err_seq", err_seq_s, m_seq);
        chk("s_err_dwell", err_dwell_s, m_dwell);
        if (done_pulse_b) n_done++;
        if (load_en_b) n_load++;
    end

    // Drive one sampled value; returns at posedge+2 with the model updated.
    task automatic cyc(input int s, input bit c);
        state_in = 2'(s);
        clear    = c;
        @(posedge clk);
        #1 model_step(s, c);
        #1;
    endtask

    task automatic round_from_idle(input bit clr_on_idle);
        cyc(1, 0); cyc(1, 0);
        cyc(2, 0); cyc(2, 0);
        cyc(3, 0); cyc(3, 0);
        cyc(0, clr_on_idle); cyc(0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_load_en"}, load_en_b, 0);
        chk({tag, "_process_en"}, process_en_b, 0);
        chk({tag, "_done_pulse"}, done_pulse_b, 0);
        chk({tag, "_round_count"}, round_count_b, 0);
        chk({tag, "_err_seq"}, err_seq_b, 0);
        chk({tag, "_err_dwell"}, err_dwell_b, 0);
    endtask

    initial begin
        int g, rem;
        model_reset();
        reset = 1'b0; state_in = 2'd0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        #1 reset = 1'b1;

        // Nominal: three full rounds, closed by the next IDLE
        n_done = 0; n_load = 0;
        cyc(0, 0); cyc(0, 0);
        repeat (3) round_from_idle(0);
        chk("nom_round_count", round_count_b, 3);
        chk("nom_s_round_count", round_count_s, 3);
        chk("nom_err_seq", err_seq_b, 0);
        chk("nom_err_dwell", err_dwell_b, 0);
        chk("nom_done_pulses", n_done, 3);
        chk("nom_load_cycles", n_load, 6);

        // Saturation of the narrow counter, then clear on the DONE->IDLE edge
        repeat (2) round_from_idle(0);
        chk("sat_round_count", round_count_b, 5);
        chk("sat_s_round_count", round_count_s, 3);
        round_from_idle(1);
        chk("clr_round_count", round_count_b, 0);
        chk("clr_s_round_count", round_count_s, 0);

        // IDLE->PROCESS skip, then a legal tail still counts
        cyc(2, 0);
        chk("skip_err_seq", err_seq_b, 1);
        cyc(2, 0); cyc(3, 0); cyc(3, 0); cyc(0, 0); cyc(0, 0);
        chk("skip_err_seq_sticky", err_seq_b, 1);
        chk("skip_round_count", round_count_b, 1);

        // clear together with a fresh illegal transition: error wins
        cyc(3, 1);
        chk("clr_vs_err_seq", err_seq_b, 1);
        cyc(3, 1);
        chk("clr_quiet_err_seq", err_seq_b, 0);
        chk("clr_quiet_err_dwell", err_dwell_b, 0);
        cyc(0, 0); cyc(0, 0);

        // LOAD held three cycles
        cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(2, 0);
        chk("long_load_err_dwell", err_dwell_b, DWELL_ON ? 1 : 0);
        chk("long_load_err_seq", err_seq_b, 0);
        cyc(2, 0); cyc(3, 0); cyc(3, 0); cyc(0, 1); cyc(0, 0);

        // Random streams: mostly legal, random dwell, occasional jumps and clears
        g = 0; rem = 0;
        for (int i = 0; i < 600; i++) begin
            if (rem == 0) begin
                g   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : (g + 1) % 4;
                rem = ($urandom_range(0, 24) == 0) ? 18 : int'($urandom_range(1, 3));
            end
            cyc(g, $urandom_range(0, 19) == 0);
            rem--;
        end

        // Reset in the middle of PROCESS
        cyc(1, 1); cyc(2, 0); cyc(2, 0);
        reset = 1'b0;
        #1 model_reset();
        check_all_zero("midrst");
        state_in = 2'd0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        cyc(0, 0); cyc(0, 0);
        repeat (2) round_from_idle(0);
        chk("post_rst_round_count", round_count_b, 2);
        chk("post_rst_err_seq", err_seq_b, 0);
        chk("post_rst_err_dwell", err_dwell_b, 0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
